// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and default operand width shared by the
// multiply/divide unit and its bench.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 16;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZDIV = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate of a W-bit value; used for
// operand magnitudes and for sign correction of results.
module muldiv_sign_fix #(
    parameter int unsigned W = 16
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/DIV responder (shift-add / restoring) writing Hi/Lo.
// Signed MULT/DIV is compiled in only when MULDIV_SIGNED_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e               r_state;
    state_e               w_state_next;
    logic [CntW-1:0]      r_cnt;
    logic                 r_is_div;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_is_div;
    logic                 w_zdiv;
    logic                 w_last;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_prem;
    logic [WIDTH+1:0]     w_trial;
    logic                 w_unused_trial;

    assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
    assign w_zdiv   = w_is_div && (inB == '0);
    assign w_last   = (r_cnt == CntW'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
    logic               w_op_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_neg_a     = w_op_signed & inA[WIDTH-1];
    assign w_neg_b     = w_op_signed & inB[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
        end
    end

    muldiv_sign_fix #(.W(2 * WIDTH)) u_fix_prod (
        .i_neg (r_sign_a ^ r_sign_b),
        .i_val (r_acc),
        .o_val (w_prod_fix)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
        .i_neg (r_sign_a ^ r_sign_b),
        .i_val (r_acc[WIDTH-1:0]),
        .o_val (w_quo_fix)
    );

    // Remainder follows the dividend's sign.
    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .i_neg (r_sign_a),
        .i_val (r_acc[2*WIDTH-1:WIDTH]),
        .o_val (w_rem_fix)
    );

    assign w_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
`else
    assign w_neg_a  = 1'b0;
    assign w_neg_b  = 1'b0;
    assign w_res_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_acc[WIDTH-1:0];
`endif

    muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
        .i_neg (w_neg_a),
        .i_val (inA),
        .o_val (w_mag_a)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
        .i_neg (w_neg_b),
        .i_val (inB),
        .o_val (w_mag_b)
    );

    // r_acc is {product} for multiply, {remainder, dividend->quotient} for divide.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({(WIDTH + 1){r_acc[0]}} & {1'b0, r_a});
        w_prem     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial    = {1'b0, w_prem} - {2'b00, r_b};
        w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_trial[WIDTH+1]) begin
                w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = {w_prem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A successful trial leaves a remainder below the divisor, so its top bit is always 0.
    assign w_unused_trial = w_trial[WIDTH];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = w_zdiv ? ZDIV : RUN;
            RUN:     if (w_last) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            ZDIV:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_a      <= w_zdiv ? inA : w_mag_a;
                        r_b      <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CntW'(1);
                end
                FIX: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_dbz  <= 1'b0;
                    r_done <= 1'b1;
                end
                ZDIV: begin
                    r_hi   <= r_a;
                    r_lo   <= '1;
                    r_dbz  <= 1'b1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
